// File: rtl/seq_pkg.sv
// Shared types and helpers for the serial sequence front end.
// Holds the FSM state enum, the default idle line level and the counter sizing helper.
package seq_pkg;

   typedef enum logic [0:0] {
      StIdle,
      StShift
   } seq_state_e;

   localparam logic IdleBitDefault = 1'b1;

   // One extra count value is reserved so the parity build's extra cycle still fits.
   function automatic int unsigned cnt_width(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out, MSB first.
// Optional trailing even-parity bit per word when SEQ_SERIALIZER_PARITY_EN is defined.
module seq_serializer
   import seq_pkg::*;
#(
   parameter int unsigned WIDTH    = 8,
   parameter logic        IDLE_BIT = IdleBitDefault
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] in_data_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   output logic             x_o,
   output logic             x_valid_o,
   output logic             word_done_o,
   output logic             busy_o
);

   localparam int unsigned CntW = cnt_width(WIDTH);
`ifdef SEQ_SERIALIZER_PARITY_EN
   localparam int unsigned LastInt = WIDTH;
`else
   localparam int unsigned LastInt = WIDTH - 1;
`endif
   localparam logic [CntW-1:0] LastIdx = CntW'(LastInt);

   seq_state_e       state_q, state_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic             hold_full_q, hold_full_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             word_done_q, word_done_d;
   logic             busy_q, busy_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
   logic             par_q, par_d;
`endif

   logic load_pt;
   logic xfer;

   assign load_pt = (state_q == StIdle) || (cnt_q == LastIdx);
   assign xfer    = in_valid_i && !hold_full_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
`ifdef SEQ_SERIALIZER_PARITY_EN
      par_d       = par_q;
`endif

      if (load_pt) begin
         cnt_d = '0;
         if (hold_full_q) begin
            // in_ready is low here, so no transfer can collide with the drain.
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            state_d     = StShift;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_d       = ^hold_q;
`endif
         end else if (xfer) begin
            shift_d = in_data_i;
            state_d = StShift;
`ifdef SEQ_SERIALIZER_PARITY_EN
            par_d   = ^in_data_i;
`endif
         end else begin
            state_d = StIdle;
         end
      end else begin
         shift_d = {shift_q[WIDTH-2:0], 1'b0};
         cnt_d   = cnt_q + CntW'(1);
         if (xfer) begin
            hold_d      = in_data_i;
            hold_full_d = 1'b1;
         end
      end
   end

   // Outputs are computed from next state so they leave the block straight from flops.
   always_comb begin
      x_valid_d   = (state_d == StShift);
      word_done_d = x_valid_d && (cnt_d == LastIdx);
      busy_d      = x_valid_d || hold_full_d;
      if (!x_valid_d) begin
         x_d = IDLE_BIT;
`ifdef SEQ_SERIALIZER_PARITY_EN
      end else if (cnt_d == CntW'(WIDTH)) begin
         x_d = par_d;
`endif
      end else begin
         x_d = shift_d[WIDTH-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         x_q         <= IDLE_BIT;
         x_valid_q   <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         x_q         <= x_d;
         x_valid_q   <= x_valid_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
`ifdef SEQ_SERIALIZER_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

   assign in_ready_o  = !hold_full_q;
   assign x_o         = x_q;
   assign x_valid_o   = x_valid_q;
   assign word_done_o = word_done_q;
   assign busy_o      = busy_q;

endmodule
